exe_stage: RTL and testbench

//  Execute stage of the 5-stage ARM pipeline; consumes the ID/EXE register outputs.

---
 rtl/exe_stage_pkg.sv | 31 +++
 rtl/exe_stage_if.sv | 65 ++++++
 rtl/exe_stage_val2_generator.sv | 52 +++++
 rtl/exe_stage.sv | 134 +++++++++++++
 tb/tb_exe_stage.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Package for the ARM execute stage.
// Holds the ALU command encodings, shifter type encodings and the bit
// positions of the {N,Z,C,V} status register. Imported by every file of the
// execute-stage slice.
package exe_stage_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_MVN = 4'b1001,
    CMD_ADD = 4'b0010,  // also LDR/STR address generation
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,  // also CMP
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,  // also TST
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

endpackage

// File: rtl/exe_stage_if.sv
// Bundle of all execute-stage data/control signals: the ID/EXE register
// outputs feeding the stage, the stall input, and the EXE/MEM, branch and
// status outputs.
//   slave  : execute stage (consumes ID/EXE fields, drives results)
//   master : upstream/downstream environment (drives ID/EXE fields)
// Optional macro FORWARDING_EN adds sel_src1/sel_src2/mem_fwd_val/wb_fwd_val.
// There is no valid/ready handshake: the stage advances every cycle unless
// freeze is high, in which case the EXE/MEM register and sr hold.
interface exe_stage_if #(parameter int WIDTH = 32);
  import exe_stage_pkg::*;

  logic              freeze;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic              b_in;
  logic              s_in;
  logic [3:0]        exe_cmd_in;
  logic              imm_in;
  logic [WIDTH-1:0]  val_rn_in;
  logic [WIDTH-1:0]  val_rm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [3:0]        dest_in;
  logic [WIDTH-1:0]  pc_in;
`ifdef FORWARDING_EN
  logic [1:0]        sel_src1;
  logic [1:0]        sel_src2;
  logic [WIDTH-1:0]  mem_fwd_val;
  logic [WIDTH-1:0]  wb_fwd_val;
`endif

  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH-1:0]  st_val;
  logic [3:0]        dest;
  logic              branch_taken;
  logic [WIDTH-1:0]  branch_addr;
  logic [3:0]        sr;

  modport slave (
    input  freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           imm_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           dest_in, pc_in,
`ifdef FORWARDING_EN
    input  sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
`endif
    output wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest, branch_taken,
           branch_addr, sr
  );

  modport master (
    output freeze, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           imm_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           dest_in, pc_in,
`ifdef FORWARDING_EN
    output sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
`endif
    input  wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest, branch_taken,
           branch_addr, sr
  );

endinterface

// File: rtl/exe_stage_val2_generator.sv
// Combinational second-operand (Val2) generator.
// Ports:
//   val_rm        in  WIDTH  register operand to be shifted
//   shift_operand in  12     shifter operand field
//   imm           in  1      I bit (rotated 8-bit immediate)
//   mem_en        in  1      load/store: 12-bit unsigned offset
//   val2          out WIDTH  selected second operand
module val2_generator
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_rm,
  input  logic [11:0]      shift_operand,
  input  logic             imm,
  input  logic             mem_en,
  output logic [WIDTH-1:0] val2
);

  logic [WIDTH-1:0]   imm_ext;
  logic [4:0]         rot_amt;
  logic [4:0]         sh_amt;
  logic [2*WIDTH-1:0] imm_dbl;
  logic [2*WIDTH-1:0] rm_dbl;
  logic [WIDTH-1:0]   shifted;

  assign imm_ext = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
  assign rot_amt = {shift_operand[11:8], 1'b0};
  assign sh_amt  = shift_operand[11:7];

  // Rotate right by shifting a doubled copy; the low half is the result.
  assign imm_dbl = {imm_ext, imm_ext} >> rot_amt;
  assign rm_dbl  = {val_rm, val_rm} >> sh_amt;

  always_comb begin
    shifted = val_rm;
    case (shift_e'(shift_operand[6:5]))
      SH_LSL:  shifted = val_rm << sh_amt;
      SH_LSR:  shifted = val_rm >> sh_amt;
      SH_ASR:  shifted = $unsigned($signed(val_rm) >>> sh_amt);
      SH_ROR:  shifted = rm_dbl[WIDTH-1:0];
      default: shifted = val_rm;
    endcase
  end

  always_comb begin
    val2 = shifted;
    if (mem_en)   val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    else if (imm) val2 = imm_dbl[WIDTH-1:0];
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline.
// Builds Val2, runs the ALU, computes the branch target, holds the NZCV
// status register and registers results into the EXE/MEM register.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-low reset (dominates freeze)
//   bus  exe_stage_if.slave: ID/EXE fields + freeze in; EXE/MEM, branch, sr out
// Parameters: WIDTH (datapath width), SR_RST (status register reset value).
// Optional macro FORWARDING_EN: operand muxes selecting ID value,
// mem_fwd_val or wb_fwd_val for rn (sel_src1) and rm/store data (sel_src2).
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] SR_RST = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  exe_stage_if.slave bus
);

  logic [WIDTH-1:0] op_rn;
  logic [WIDTH-1:0] op_rm;
  logic [WIDTH-1:0] val2;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c_nxt;
  logic             v_nxt;
  logic [3:0]       flags_nxt;
  logic [3:0]       sr_q;

`ifdef FORWARDING_EN
  always_comb begin
    op_rn = bus.val_rn_in;
    case (bus.sel_src1)
      2'b01:   op_rn = bus.mem_fwd_val;
      2'b10:   op_rn = bus.wb_fwd_val;
      default: op_rn = bus.val_rn_in;
    endcase
  end

  always_comb begin
    op_rm = bus.val_rm_in;
    case (bus.sel_src2)
      2'b01:   op_rm = bus.mem_fwd_val;
      2'b10:   op_rm = bus.wb_fwd_val;
      default: op_rm = bus.val_rm_in;
    endcase
  end
`else
  assign op_rn = bus.val_rn_in;
  assign op_rm = bus.val_rm_in;
`endif

  val2_generator #(.WIDTH(WIDTH)) u_val2 (
    .val_rm        (op_rm),
    .shift_operand (bus.shift_operand_in),
    .imm           (bus.imm_in),
    .mem_en        (bus.mem_r_en_in | bus.mem_w_en_in),
    .val2          (val2)
  );

  // Subtraction is rn + ~val2 + carry_in so that bit WIDTH is NOT borrow.
  always_comb begin
    sum   = '0;
    res   = '0;
    c_nxt = sr_q[SR_C];
    v_nxt = sr_q[SR_V];
    case (exe_cmd_e'(bus.exe_cmd_in))
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum = {1'b0, op_rn} + {1'b0, val2}
            + {{WIDTH{1'b0}}, (bus.exe_cmd_in == CMD_ADC) & sr_q[SR_C]};
        res   = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = (op_rn[WIDTH-1] == val2[WIDTH-1]) && (res[WIDTH-1] != op_rn[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        sum = {1'b0, op_rn} + {1'b0, ~val2}
            + {{WIDTH{1'b0}}, (bus.exe_cmd_in == CMD_SUB) | sr_q[SR_C]};
        res   = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = (op_rn[WIDTH-1] != val2[WIDTH-1]) && (res[WIDTH-1] != op_rn[WIDTH-1]);
      end
      CMD_AND: res = op_rn & val2;
      CMD_ORR: res = op_rn | val2;
      CMD_EOR: res = op_rn ^ val2;
      default: res = '0;
    endcase
  end

  always_comb begin
    flags_nxt        = sr_q;
    flags_nxt[SR_N]  = res[WIDTH-1];
    flags_nxt[SR_Z]  = (res == '0);
    flags_nxt[SR_C]  = c_nxt;
    flags_nxt[SR_V]  = v_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= SR_RST;
    end else if (!bus.freeze && bus.s_in) begin
      sr_q <= flags_nxt;
    end
  end

  // EXE/MEM pipeline register
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wb_en    <= 1'b0;
      bus.mem_r_en <= 1'b0;
      bus.mem_w_en <= 1'b0;
      bus.alu_res  <= '0;
      bus.st_val   <= '0;
      bus.dest     <= 4'hF;
    end else if (!bus.freeze) begin
      bus.wb_en    <= bus.wb_en_in;
      bus.mem_r_en <= bus.mem_r_en_in;
      bus.mem_w_en <= bus.mem_w_en_in;
      bus.alu_res  <= res;
      bus.st_val   <= op_rm;
      bus.dest     <= bus.dest_in;
    end
  end

  assign bus.sr           = sr_q;
  assign bus.branch_taken = bus.b_in;
  // Word offset: sign-extend, then scale by 4; wraps modulo 2^WIDTH.
  assign bus.branch_addr  = bus.pc_in
                          + {{(WIDTH-26){bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];

  exe_stage_if #(.WIDTH(32)) bus ();

  exe_stage #(.WIDTH(32), .SR_RST(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: apply one instruction's ID/EXE fields
  task automatic drive_op(input logic [3:0] cmd, input logic s, input logic imm,
                          input logic [31:0] rn, input logic [31:0] rm,
                          input logic [11:0] shop, input logic mr, input logic mw,
                          input logic wb, input logic [3:0] dst);
    bus.exe_cmd_in       = cmd;
    bus.s_in             = s;
    bus.imm_in           = imm;
    bus.val_rn_in        = rn;
    bus.val_rm_in        = rm;
    bus.shift_operand_in = shop;
    bus.mem_r_en_in      = mr;
    bus.mem_w_en_in      = mw;
    bus.wb_en_in         = wb;
    bus.dest_in          = dst;
  endtask

  // push expected result, clock once, compare against scoreboard head
  task automatic run_op(input string tag, input logic [3:0] cmd, input logic s,
                        input logic imm, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [11:0] shop, input logic [31:0] exp_res,
                        input logic [3:0] exp_sr);
    logic [31:0] e;
    drive_op(cmd, s, imm, rn, rm, shop, 1'b0, 1'b0, 1'b1, 4'h2);
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val({tag, "_res"}, bus.alu_res, e);
    check_val({tag, "_sr"}, {28'b0, bus.sr}, {28'b0, exp_sr});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.freeze           = 1'b1;
    bus.b_in             = 1'b0;
    bus.pc_in            = '0;
    bus.signed_imm_24_in = '0;
`ifdef FORWARDING_EN
    bus.sel_src1    = 2'b00;
    bus.sel_src2    = 2'b00;
    bus.mem_fwd_val = 32'hDEAD_0001;
    bus.wb_fwd_val  = 32'hDEAD_0002;
`endif
    drive_op(CMD_ADD, 1'b1, 1'b1, 32'h1234, 32'h5678, 12'h0FF, 1'b1, 1'b1, 1'b1, 4'h3);

    // reset dominates freeze
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_dest", {28'b0, bus.dest}, 32'hF);
    check_val("rst_sr", {28'b0, bus.sr}, 32'h0);
    check_val("rst_alu", bus.alu_res, 32'h0);
    check_val("rst_st", bus.st_val, 32'h0);
    check_val("rst_ctl", {29'b0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'h0);

    rst        = 1'b1;
    bus.freeze = 1'b0;

    // ADD signed overflow -> N,V
    run_op("add_ovf", CMD_ADD, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1234, 12'h001,
           32'h8000_0000, 4'b1001);
    check_val("add_st", bus.st_val, 32'h1234);
    check_val("add_wb", {31'b0, bus.wb_en}, 32'h1);
    check_val("add_dest", {28'b0, bus.dest}, 32'h2);
    // CMP equal -> Z,C ; then ADC picks up carry
    run_op("cmp", CMD_SUB, 1'b1, 1'b0, 32'd5, 32'd5, 12'h000, 32'h0, 4'b0110);
    run_op("adc", CMD_ADC, 1'b0, 1'b1, 32'd1, 32'd0, 12'h000, 32'd2, 4'b0110);
    // rotated immediate 0xFF ror 8
    run_op("imm_rot", CMD_MOV, 1'b0, 1'b1, 32'd0, 32'd0, 12'h4FF, 32'hFF00_0000, 4'b0110);
    // register shifts
    run_op("asr", CMD_MOV, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 12'h240, 32'hF800_0000, 4'b0110);
    run_op("lsr", CMD_MOV, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 12'h220, 32'h0800_0000, 4'b0110);
    run_op("ror", CMD_MOV, 1'b0, 1'b0, 32'd0, 32'h0000_000F, 12'h260, 32'hF000_0000, 4'b0110);
    run_op("lsl31", CMD_MOV, 1'b0, 1'b0, 32'd0, 32'h0000_0001, 12'hF80, 32'h8000_0000, 4'b0110);
    run_op("mvn", CMD_MVN, 1'b0, 1'b0, 32'd0, 32'h0F0F_0F0F, 12'h000, 32'hF0F0_F0F0, 4'b0110);

    // LDR: zero-extended 12-bit offset
    drive_op(CMD_ADD, 1'b0, 1'b0, 32'h1000, 32'h0, 12'hFFC, 1'b1, 1'b0, 1'b1, 4'h5);
    @(posedge clk);
    #1;
    check_val("ldr_addr", bus.alu_res, 32'h1FFC);
    check_val("ldr_ctl", {29'b0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'b100 | 32'b010);
    check_val("ldr_dest", {28'b0, bus.dest}, 32'h5);

    // STR: store data from rm
    drive_op(CMD_ADD, 1'b0, 1'b0, 32'h2000, 32'hCAFE, 12'h004, 1'b0, 1'b1, 1'b0, 4'h6);
    @(posedge clk);
    #1;
    check_val("str_addr", bus.alu_res, 32'h2004);
    check_val("str_data", bus.st_val, 32'hCAFE);
    check_val("str_ctl", {29'b0, bus.wb_en, bus.mem_r_en, bus.mem_w_en}, 32'b001);

    // freeze with s_in: everything holds, branch still live
    bus.freeze = 1'b1;
    drive_op(CMD_MVN, 1'b1, 1'b1, 32'd0, 32'h1111, 12'h000, 1'b0, 1'b0, 1'b1, 4'h7);
    bus.b_in             = 1'b1;
    bus.pc_in            = 32'h100;
    bus.signed_imm_24_in = 24'hFFFFFE;
    #1;
    check_val("br_taken", {31'b0, bus.branch_taken}, 32'h1);
    check_val("br_addr", bus.branch_addr, 32'h0000_00F8);
    @(posedge clk);
    #1;
    check_val("frz_alu", bus.alu_res, 32'h2004);
    check_val("frz_sr", {28'b0, bus.sr}, 32'h6);
    check_val("frz_st", bus.st_val, 32'hCAFE);
    check_val("frz_dest", {28'b0, bus.dest}, 32'h6);
    bus.signed_imm_24_in = 24'h000010;
    #1;
    check_val("br_fwd", bus.branch_addr, 32'h0000_0140);
    bus.freeze = 1'b0;
    bus.b_in   = 1'b0;
    #1;
    check_val("br_nt", {31'b0, bus.branch_taken}, 32'h0);

    // logic ops keep C,V
    run_op("orr", CMD_ORR, 1'b1, 1'b1, 32'hF0, 32'd0, 12'h00F, 32'hFF, 4'b0010);
    run_op("and", CMD_AND, 1'b1, 1'b1, 32'hF0, 32'd0, 12'h00F, 32'h0, 4'b0110);
    run_op("eor", CMD_EOR, 1'b0, 1'b1, 32'hFF, 32'd0, 12'h00F, 32'hF0, 4'b0110);
    // borrow clears C, then SBC subtracts the extra 1
    run_op("sub_brw", CMD_SUB, 1'b1, 1'b1, 32'd3, 32'd0, 12'h005, 32'hFFFF_FFFE, 4'b1000);
    run_op("sbc", CMD_SBC, 1'b1, 1'b1, 32'd5, 32'd0, 12'h003, 32'd1, 4'b0010);
    // undefined command: result 0, Z set, C/V kept
    run_op("undef", 4'b1111, 1'b1, 1'b1, 32'd7, 32'd0, 12'h003, 32'd0, 4'b0110);
    // 33-bit wrap: carry out
    run_op("add_wrap", CMD_ADD, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 12'h002, 32'd1, 4'b0010);

    // mid-run reset
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("rst2_sr", {28'b0, bus.sr}, 32'h0);
    check_val("rst2_dest", {28'b0, bus.dest}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
